// File: rtl/turbo_pkg.sv
// rtl/turbo_pkg.sv - shared types and constants for the turbo block encoder
package turbo_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    ENC  = 2'd1,
    TAIL = 2'd2
  } state_e;

  localparam int SYS = 0;
  localparam int P1  = 1;
  localparam int P2  = 2;

  // Generator polynomials, MSB = D^0 tap: feedback 13 octal, feedforward 15 octal
  localparam logic [3:0] RSC_FB = 4'b1011;
  localparam logic [3:0] RSC_FF = 4'b1101;

  localparam int TAIL_LEN = 3;

  // XOR of the delay taps selected by poly[2:0] (D^1..D^3) over state {s3,s2,s1}
  function automatic logic rsc_tap(input logic [2:0] taps, input logic [2:0] st);
    return (taps[2] & st[0]) ^ (taps[1] & st[1]) ^ (taps[0] & st[2]);
  endfunction

endpackage

// File: rtl/rsc_enc_step.sv
// rtl/rsc_enc_step.sv - one combinational trellis step of a 13/15 RSC encoder
module rsc_enc_step
  import turbo_pkg::*;
(
  input  logic       u_i,
  input  logic [2:0] state_i,
  input  logic       tail_i,
  output logic       parity_o,
  output logic       tail_u_o,
  output logic [2:0] next_state_o
);

  logic fb;
  logic a;

  assign fb       = rsc_tap(RSC_FB[2:0], state_i);
  assign tail_u_o = fb;
  // Termination drives the feedback node to zero so the register flushes in 3 steps
  assign a        = tail_i ? 1'b0 : (u_i ^ fb);
  assign parity_o = (RSC_FF[3] & a) ^ rsc_tap(RSC_FF[2:0], state_i);
  assign next_state_o = {state_i[1], state_i[0], a};

endmodule

// File: rtl/turbo_encoder_blk.sv
// rtl/turbo_encoder_blk.sv - block turbo encoder: serial K-bit load, then
// one {p2,p1,sys} symbol per accepted cycle with optional trellis termination
module turbo_encoder_blk
  import turbo_pkg::*;
#(
  parameter int K         = 16,
  parameter int IL_A      = 5,
  parameter int IL_B      = 3,
  parameter int TERMINATE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out_data,
  output logic       out_last,
  output logic       out_tail,
  output logic       busy
);

  localparam int AW = $clog2(K);
  localparam logic [AW-1:0] LAST_IDX  = AW'(K - 1);
  localparam logic [AW-1:0] IL_A_W    = AW'(IL_A);
  localparam logic [AW-1:0] IL_B_W    = AW'(IL_B);
  localparam logic [1:0]    TAIL_LAST = 2'(TAIL_LEN - 1);

  state_e          state_q;
  logic [AW-1:0]   cnt_q;
  logic [AW-1:0]   pi_q;
  logic [1:0]      tcnt_q;
  logic [2:0]      rsc1_q, rsc2_q;
  logic [2:0]      rsc1_d, rsc2_d;
  logic [K-1:0]    buf_q;

  logic in_tail;
  logic accept;
  logic load_beat;
  logic u1, u2;
  logic tu1, tu2;
  logic p1, p2;

  assign in_tail   = (state_q == TAIL);
  assign out_valid = (state_q != LOAD);
  assign in_ready  = (state_q == LOAD);
  assign busy      = out_valid;
  assign accept    = out_valid & out_ready;
  assign load_beat = in_ready & in_valid;

  // During termination each encoder is fed its own feedback bit
  assign u1 = in_tail ? tu1 : buf_q[cnt_q];
  assign u2 = in_tail ? tu2 : buf_q[pi_q];

  rsc_enc_step u_rsc1 (
    .u_i          (u1),
    .state_i      (rsc1_q),
    .tail_i       (in_tail),
    .parity_o     (p1),
    .tail_u_o     (tu1),
    .next_state_o (rsc1_d)
  );

  rsc_enc_step u_rsc2 (
    .u_i          (u2),
    .state_i      (rsc2_q),
    .tail_i       (in_tail),
    .parity_o     (p2),
    .tail_u_o     (tu2),
    .next_state_o (rsc2_d)
  );

  always_comb begin
    out_data = 3'b000;
    if (out_valid) begin
      out_data[SYS] = u1;
      out_data[P1]  = p1;
      out_data[P2]  = p2;
    end
  end

  assign out_tail = in_tail;
  assign out_last = ((state_q == ENC) && (cnt_q == LAST_IDX) && (TERMINATE == 0)) ||
                    (in_tail && (tcnt_q == TAIL_LAST));

  // Block storage carries no reset: its contents only matter after a full load
  always_ff @(posedge clk) begin
    if (load_beat) begin
      buf_q[cnt_q] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      pi_q    <= '0;
      tcnt_q  <= '0;
      rsc1_q  <= '0;
      rsc2_q  <= '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (in_valid) begin
            if (cnt_q == LAST_IDX) begin
              cnt_q   <= '0;
              pi_q    <= IL_B_W;
              rsc1_q  <= '0;
              rsc2_q  <= '0;
              state_q <= ENC;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        ENC: begin
          if (accept) begin
            rsc1_q <= rsc1_d;
            rsc2_q <= rsc2_d;
            pi_q   <= pi_q + IL_A_W;
            if (cnt_q == LAST_IDX) begin
              cnt_q   <= '0;
              tcnt_q  <= '0;
              state_q <= (TERMINATE != 0) ? TAIL : LOAD;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        TAIL: begin
          if (accept) begin
            rsc1_q <= rsc1_d;
            rsc2_q <= rsc2_d;
            if (tcnt_q == TAIL_LAST) begin
              tcnt_q  <= '0;
              state_q <= LOAD;
            end else begin
              tcnt_q <= tcnt_q + 1'b1;
            end
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_turbo_encoder_blk.sv
// tb/tb_turbo_encoder_blk.sv - self-checking bench for turbo_encoder_blk
module tb_turbo_encoder_blk;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_data = 1'b0;
  logic out_ready = 1'b0;

  always #5 clk = ~clk;

  logic       ir0, ov0, ol0, ot0, bz0;
  logic [2:0] od0;
  logic       ir1, ov1, ol1, ot1, bz1;
  logic [2:0] od1;
  logic       ir2, ov2, ol2, ot2, bz2;
  logic [2:0] od2;

  turbo_encoder_blk #(.K(16), .IL_A(5), .IL_B(3), .TERMINATE(1)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_last(ol0),
    .out_tail(ot0), .busy(bz0)
  );

  turbo_encoder_blk #(.K(8), .IL_A(3), .IL_B(0), .TERMINATE(1)) u_dut8t (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_last(ol1),
    .out_tail(ot1), .busy(bz1)
  );

  turbo_encoder_blk #(.K(8), .IL_A(3), .IL_B(0), .TERMINATE(0)) u_dut8n (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir2), .in_data(in_data),
    .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .out_last(ol2),
    .out_tail(ot2), .busy(bz2)
  );

  int sel = 0;
  logic       ir, ov, ol, ot, bz;
  logic [2:0] od;

  always_comb begin
    case (sel)
      1:       {ir, ov, ol, ot, bz, od} = {ir1, ov1, ol1, ot1, bz1, od1};
      2:       {ir, ov, ol, ot, bz, od} = {ir2, ov2, ol2, ot2, bz2, od2};
      default: {ir, ov, ol, ot, bz, od} = {ir0, ov0, ol0, ot0, bz0, od0};
    endcase
  end

  typedef struct packed {
    logic       last;
    logic       tail;
    logic [2:0] data;
  } sym_t;

  int   passed = 0;
  int   total = 0;
  sym_t exp_q[$];
  sym_t got_q[$];
  logic [5:0] model_fin;
  int   busy_cycles;

  // Polynomial view: w = u + D^2 w + D^3 w ; p = w + D w + D^3 w; q[0]=D^1, q[2]=D^3
  function automatic logic [3:0] rsc_model(input logic [2:0] q, input logic u);
    logic w;
    w = u ^ q[1] ^ q[2];
    return {w ^ q[0] ^ q[2], q[1], q[0], w};
  endfunction

  task automatic model_block(input logic [255:0] blk, input int k, input int a,
                             input int b, input int t);
    logic [2:0] q1 = 3'b000;
    logic [2:0] q2 = 3'b000;
    logic [3:0] r1, r2;
    logic       v1, v2;
    sym_t       s;
    for (int i = 0; i < k; i++) begin
      v1 = blk[i];
      v2 = blk[(a * i + b) % k];
      r1 = rsc_model(q1, v1);
      r2 = rsc_model(q2, v2);
      q1 = r1[2:0];
      q2 = r2[2:0];
      s.last = (t == 0) && (i == k - 1);
      s.tail = 1'b0;
      s.data = {r2[3], r1[3], v1};
      exp_q.push_back(s);
    end
    if (t != 0) begin
      for (int j = 0; j < 3; j++) begin
        v1 = q1[1] ^ q1[2];
        v2 = q2[1] ^ q2[2];
        r1 = rsc_model(q1, v1);
        r2 = rsc_model(q2, v2);
        q1 = r1[2:0];
        q2 = r2[2:0];
        s.last = (j == 2);
        s.tail = 1'b1;
        s.data = {r2[3], r1[3], v1};
        exp_q.push_back(s);
      end
    end
    model_fin = {q2, q1};
  endtask

  task automatic do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic load_block(input logic [255:0] blk, input int k);
    int guard;
    for (int i = 0; i < k; i++) begin
      guard = 0;
      while (!ir && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 50) begin
        total++;
        $display("FAIL load_timeout bit %0d in_ready=%b required 1", i, ir);
      end
      in_valid = 1'b1;
      in_data  = blk[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic collect(input int nsym, input int ready_pct, input bit noise);
    int   got = 0;
    int   cyc = 0;
    bit   stall = 0;
    logic [5:0] held = '0;
    sym_t e, g;
    got_q.delete();
    busy_cycles = 0;
    while (got < nsym && cyc < 2000) begin
      if (stall) begin
        total++;
        if ({ov, ol, ot, od} !== held) $display("FAIL hold cyc %0d got %b required %b", cyc, {ov, ol, ot, od}, held);
        else passed++;
      end
      if (bz) busy_cycles++;
      if (noise) begin
        in_valid = 1'b1;
        in_data  = 1'($urandom);
      end
      out_ready = ($urandom_range(99) < ready_pct);
      if (ov && out_ready) begin
        g = {ol, ot, od};
        total++;
        if (exp_q.size() == 0) begin
          $display("FAIL extra_symbol %0d got %b required none", got, g);
        end else begin
          e = exp_q.pop_front();
          if (g !== e) $display("FAIL sym[%0d] got last/tail/data %b required %b", got, g, e);
          else passed++;
        end
        got_q.push_back(g);
        got++;
        stall = 0;
      end else begin
        stall = ov;
        held  = {ov, ol, ot, od};
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    total++;
    if (got < nsym) $display("FAIL collect_timeout got %0d symbols required %0d", got, nsym);
    else passed++;
    total++;
    if ({ov, ir, bz} !== 3'b010) $display("FAIL idle_after_block ov/ir/busy %b required 010", {ov, ir, bz});
    else passed++;
  endtask

  task automatic test_reset();
    sel   = 0;
    rst_n = 1'b0;
    #3;
    total++; if (ir !== 1'b1)    $display("FAIL reset_in_ready %b required 1", ir);       else passed++;
    total++; if (ov !== 1'b0)    $display("FAIL reset_out_valid %b required 0", ov);      else passed++;
    total++; if (od !== 3'b000)  $display("FAIL reset_out_data %b required 000", od);     else passed++;
    total++; if (ol !== 1'b0)    $display("FAIL reset_out_last %b required 0", ol);       else passed++;
    total++; if (ot !== 1'b0)    $display("FAIL reset_out_tail %b required 0", ot);       else passed++;
    total++; if (bz !== 1'b0)    $display("FAIL reset_busy %b required 0", bz);           else passed++;
  endtask

  task automatic test_all_zero();
    int ntail = 0;
    int nlast = 0;
    sel = 0;
    do_reset();
    exp_q.delete();
    model_block('0, 16, 5, 3, 1);
    load_block('0, 16);
    collect(19, 100, 0);
    total++;
    if (busy_cycles != 19) $display("FAIL zero_busy_cycles %0d required 19", busy_cycles);
    else passed++;
    for (int i = 0; i < got_q.size(); i++) begin
      if (got_q[i].tail) ntail++;
      if (got_q[i].last) nlast++;
    end
    total++;
    if (ntail != 3 || nlast != 1 || got_q.size() != 19 || !got_q[18].last)
      $display("FAIL zero_flags tails %0d lasts %0d syms %0d required 3 1 19", ntail, nlast, got_q.size());
    else passed++;
  endtask

  task automatic test_small_term();
    logic [255:0] blk = 256'd1;
    sel = 1;
    do_reset();
    exp_q.delete();
    model_block(blk, 8, 3, 0, 1);
    total++;
    if (model_fin !== 6'b0) $display("FAIL model_termination state %b required 000000", model_fin);
    else passed++;
    load_block(blk, 8);
    collect(11, 100, 0);
    total++;
    if (got_q.size() < 2 || got_q[0].data !== 3'b111 || got_q[1].data !== 3'b110)
      $display("FAIL small_first_syms got %b %b required 111 110",
               (got_q.size() > 0) ? got_q[0].data : 3'bxxx, (got_q.size() > 1) ? got_q[1].data : 3'bxxx);
    else passed++;
  endtask

  task automatic test_random_blocks();
    logic [255:0] blk;
    sel = 0;
    do_reset();
    exp_q.delete();
    for (int n = 0; n < 100; n++) begin
      blk = 256'($urandom);
      model_block(blk, 16, 5, 3, 1);
      load_block(blk, 16);
      collect(19, 50, 0);
    end
  endtask

  task automatic test_no_term();
    logic [255:0] blk;
    int ntail = 0;
    sel = 2;
    do_reset();
    exp_q.delete();
    for (int n = 0; n < 3; n++) begin
      blk = 256'($urandom);
      model_block(blk, 8, 3, 0, 0);
      load_block(blk, 8);
      collect(8, (n == 0) ? 100 : 50, 0);
      for (int i = 0; i < got_q.size(); i++) if (got_q[i].tail) ntail++;
    end
    total++;
    if (ntail != 0) $display("FAIL noterm_tail_count %0d required 0", ntail);
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic [255:0] blk;
    sel = 0;
    do_reset();
    exp_q.delete();
    blk = 256'($urandom);
    load_block(blk, 16);
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (ov !== 1'b0) $display("FAIL async_reset_out_valid %b required 0", ov);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (ir !== 1'b1) $display("FAIL post_reset_in_ready %b required 1", ir);
    else passed++;
    blk = 256'($urandom);
    model_block(blk, 16, 5, 3, 1);
    load_block(blk, 16);
    collect(19, 50, 0);
  endtask

  task automatic test_ignore_input();
    logic [255:0] blk;
    sel = 0;
    do_reset();
    exp_q.delete();
    for (int n = 0; n < 3; n++) begin
      blk = 256'($urandom);
      model_block(blk, 16, 5, 3, 1);
      load_block(blk, 16);
      collect(19, 50, 1);
    end
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_small_term();
    test_random_blocks();
    test_no_term();
    test_reset_mid();
    test_ignore_input();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
